// File: rtl/pc_jump_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_jump_sequencer_if : instruction-memory request/acknowledge bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pc_jump_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/pc_jump_sequencer.sv
// ---------------------------------------------------------------------------
// pc_jump_sequencer : multicycle fetch / next-PC sequencer (PC, IR, jal link)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_jump_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  wire logic               clk,
    input  wire logic               reset,
    pc_jump_sequencer_if.master     imem,
    input  wire logic               stall,
    input  wire logic [31:0]        rs_val,
    input  wire logic [31:0]        rt_val,
    output logic      [31:0]        pc,
    output logic      [31:0]        ir,
    output logic      [4:0]         rs_addr,
    output logic      [4:0]         rt_addr,
    output logic                    instr_valid,
    output logic                    link_we,
    output logic      [4:0]         link_addr,
    output logic      [31:0]        link_data,
    output logic                    misalign_err
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        DECODE = 1'b1
    } state_t;

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [5:0] c_FN_JR      = 6'b001000;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_misalign;

    logic [31:0] w_p4;
    logic [31:0] w_off;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_next_pc;
    logic        w_is_jal;
    logic        w_jr_bad;
    logic        w_decode_go;

    assign w_p4       = r_pc + 32'd4;
    assign w_off      = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_jump_tgt = {w_p4[31:28], r_ir[25:0], 2'b00};

    // Reset gates the pulses combinationally so nothing leaks out of a reset cycle.
    assign w_decode_go = reset && (r_state == DECODE) && !stall;

    always_comb begin
        w_next_pc = w_p4;
        w_is_jal  = 1'b0;
        w_jr_bad  = 1'b0;
        case (r_ir[31:26])
            c_OP_J:   w_next_pc = w_jump_tgt;
            c_OP_JAL: begin
                w_next_pc = w_jump_tgt;
                w_is_jal  = 1'b1;
            end
            c_OP_BEQ: w_next_pc = (rs_val == rt_val) ? (w_p4 + w_off) : w_p4;
            c_OP_BNE: w_next_pc = (rs_val != rt_val) ? (w_p4 + w_off) : w_p4;
            c_OP_SPECIAL: begin
                if (r_ir[5:0] == c_FN_JR) begin
                    if (rs_val[1:0] == 2'b00) begin
                        w_next_pc = rs_val;
                    end else begin
                        w_next_pc = EXC_VECTOR;
                        w_jr_bad  = 1'b1;
                    end
                end
            end
            default: w_next_pc = w_p4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        r_ir    <= imem.imem_rdata;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                        if (w_jr_bad) begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem.imem_req  = reset && (r_state == FETCH);
    assign imem.imem_addr = r_pc;

    assign pc           = r_pc;
    assign ir           = r_ir;
    assign rs_addr      = r_ir[25:21];
    assign rt_addr      = r_ir[20:16];
    assign instr_valid  = w_decode_go;
    assign link_we      = w_decode_go && w_is_jal;
    assign link_addr    = 5'd31;
    assign link_data    = link_we ? w_p4 : 32'd0;
    assign misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_jump_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_jump_sequencer : table-driven directed bench for pc_jump_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_jump_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        instr_valid;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        misalign_err;

    pc_jump_sequencer_if bus ();

    pc_jump_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (bus.master),
        .stall        (stall),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .pc           (pc),
        .ir           (ir),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .instr_valid  (instr_valid),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .link_data    (link_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        int          waits;
        int          stalls;
        logic [31:0] exp_pc;
        logic        exp_lwe;
        logic [31:0] exp_ldata;
        logic        exp_mis;
    } vec_t;

    localparam logic [31:0] c_NOP  = 32'h0000_0000;
    localparam logic [31:0] c_JR   = 32'h0020_0008;
    localparam logic [31:0] c_BEQ  = 32'h1022_FFFE;
    localparam logic [31:0] c_BNE  = 32'h1422_FFFE;
    localparam logic [31:0] c_J    = 32'h0831_806B;
    localparam logic [31:0] c_JAL  = 32'h0C10_0010;
    localparam logic [31:0] c_ADD  = 32'h0022_1820;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc_now;
    vec_t        vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int reqs = 0;
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            bus.imem_ack   = (w == v.waits);
            bus.imem_rdata = v.instr;
            #1;
            if (bus.imem_req) reqs++;
            if (w == 0) chk("fetch_addr", bus.imem_addr, exp_pc_now);
        end
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rs_val = v.rs;
        rt_val = v.rt;
        for (int s = 0; s < v.stalls; s++) begin
            stall = 1'b1;
            #1;
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
            chk("stall_pc", pc, exp_pc_now);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("decode_valid", {31'd0, instr_valid}, 32'd1);
        chk("decode_req", {31'd0, bus.imem_req}, 32'd0);
        chk("link_we", {31'd0, link_we}, {31'd0, v.exp_lwe});
        chk("link_data", link_data, v.exp_ldata);
        if (v.exp_lwe) chk("link_addr", {27'd0, link_addr}, 32'd31);
        chk("rs_addr", {27'd0, rs_addr}, {27'd0, v.instr[25:21]});
        @(posedge clk);
        #1;
        chk("next_pc", pc, v.exp_pc);
        chk("misalign", {31'd0, misalign_err}, {31'd0, v.exp_mis});
        chk("req_cycles", reqs, v.waits + 1);
        exp_pc_now = v.exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            instr   rs            rt  waits stalls exp_pc        lwe  ldata         mis
        vecs[0]  = '{c_NOP, 32'd0,        32'd0, 3, 0, 32'h0040_0004, 1'b0, 32'd0,         1'b0};
        vecs[1]  = '{c_JR,  32'h6000_0000, 32'd0, 0, 0, 32'h6000_0000, 1'b0, 32'd0,         1'b0};
        vecs[2]  = '{c_J,   32'd0,        32'd0, 1, 0, 32'h60C6_01AC, 1'b0, 32'd0,         1'b0};
        vecs[3]  = '{c_JR,  32'h0040_0000, 32'd0, 0, 0, 32'h0040_0000, 1'b0, 32'd0,         1'b0};
        vecs[4]  = '{c_JAL, 32'd0,        32'd0, 2, 0, 32'h0040_0040, 1'b1, 32'h0040_0004, 1'b0};
        vecs[5]  = '{c_JR,  32'h0000_0100, 32'd0, 0, 0, 32'h0000_0100, 1'b0, 32'd0,         1'b0};
        vecs[6]  = '{c_BEQ, 32'd5,        32'd5, 0, 3, 32'h0000_00FC, 1'b0, 32'd0,         1'b0};
        vecs[7]  = '{c_JR,  32'h0000_0100, 32'd0, 0, 0, 32'h0000_0100, 1'b0, 32'd0,         1'b0};
        vecs[8]  = '{c_BNE, 32'd5,        32'd5, 0, 0, 32'h0000_0104, 1'b0, 32'd0,         1'b0};
        vecs[9]  = '{c_BNE, 32'd5,        32'd6, 0, 0, 32'h0000_0100, 1'b0, 32'd0,         1'b0};
        vecs[10] = '{c_BEQ, 32'd5,        32'd6, 0, 0, 32'h0000_0104, 1'b0, 32'd0,         1'b0};
        vecs[11] = '{c_JR,  32'h0040_0020, 32'd0, 0, 0, 32'h0040_0020, 1'b0, 32'd0,         1'b0};
        vecs[12] = '{c_JR,  32'hFFFF_FFFC, 32'd0, 0, 0, 32'hFFFF_FFFC, 1'b0, 32'd0,         1'b0};
        vecs[13] = '{c_ADD, 32'd1,        32'd2, 0, 0, 32'h0000_0000, 1'b0, 32'd0,         1'b0};
        vecs[14] = '{c_JR,  32'h0040_0022, 32'd0, 0, 0, 32'h8000_0180, 1'b0, 32'd0,         1'b1};
        vecs[15] = '{c_NOP, 32'd0,        32'd0, 0, 1, 32'h8000_0184, 1'b0, 32'd0,         1'b1};
        vecs[16] = '{c_ADD, 32'd3,        32'd4, 1, 0, 32'h8000_0188, 1'b0, 32'd0,         1'b1};

        reset = 1'b0;
        stall = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_ir", ir, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_link_we", {31'd0, link_we}, 32'd0);
        chk("rst_link_data", link_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        reset = 1'b1;
        exp_pc_now = 32'h0040_0000;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i]);
        end

        // Reset arriving while a jal sits in DECODE: no pulses, sticky flag cleared.
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = c_JAL;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstdec_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstdec_link_we", {31'd0, link_we}, 32'd0);
        chk("rstdec_link_data", link_data, 32'd0);
        chk("rstdec_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstdec_pc", pc, 32'h0040_0000);
        chk("rstdec_misalign", {31'd0, misalign_err}, 32'd0);

        // Acknowledge coincident with reset must be ignored.
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("race_ir", ir, 32'd0);
        chk("race_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk("race_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("race_fetch_addr", bus.imem_addr, 32'h0040_0000);
        exp_pc_now = 32'h0040_0000;
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
